// File: rtl/lfsr_gen_param_if.sv
// rtl/lfsr_gen_param_if.sv - control/status bundle for the parametrised LFSR payload generator
interface lfsr_gen_param_if #(
    parameter int LEN   = 22,
    parameter int SYM_W = 4
);
    logic             clk_en;
    logic             seed_load;
    logic [LEN-1:0]   seed_in;
    logic [LEN-1:0]   seq_out;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             seed_err;
    logic             cycle_out_once;
    logic             cycle_out_periodic;
    logic [LEN-1:0]   lfsr_counter;

    modport master (
        output clk_en, seed_load, seed_in,
        input  seq_out, sym_out, sym_valid, seed_err,
               cycle_out_once, cycle_out_periodic, lfsr_counter
    );

    modport slave (
        input  clk_en, seed_load, seed_in,
        output seq_out, sym_out, sym_valid, seed_err,
               cycle_out_once, cycle_out_periodic, lfsr_counter
    );
endinterface

// File: rtl/lfsr_gen_param.sv
// rtl/lfsr_gen_param.sv - Galois LFSR symbol generator with seed load and cycle detector; LFSR_STOP_ON_CYCLE_EN halts after one period
module lfsr_gen_param #(
    parameter int             LEN   = 22,
    parameter logic [LEN-1:0] POLY  = 22'h200001,
    parameter logic [LEN-1:0] SEED  = 22'h000001,
    parameter int             SYM_W = 4
) (
    input  logic clk,
    input  logic reset,
    lfsr_gen_param_if.slave bus
);

    logic [LEN-1:0] r_state;
    logic [LEN-1:0] r_act_seed;
    logic [LEN-1:0] r_counter;
    logic           r_sym_valid;
    logic           r_seed_err;
    logic           r_once;
    logic           r_periodic;

    logic [LEN-1:0] w_next;
    logic           w_load_ok;
    logic           w_wrap;
    logic           w_adv;

    // SYM_W single steps chained within one clock
    function automatic logic [LEN-1:0] advance(input logic [LEN-1:0] s);
        logic [LEN-1:0] t;
        t = s;
        for (int i = 0; i < SYM_W; i++) begin
            t = {t[LEN-2:0], 1'b0} ^ (t[LEN-1] ? POLY : '0);
        end
        return t;
    endfunction

    assign w_next    = advance(r_state);
    assign w_load_ok = bus.seed_load && (bus.seed_in != '0);
    assign w_wrap    = (w_next == r_act_seed);

`ifdef LFSR_STOP_ON_CYCLE_EN
    logic r_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_load_ok) begin
            r_halted <= 1'b0;
        end else if (!bus.seed_load && w_adv && w_wrap) begin
            r_halted <= 1'b1;
        end
    end

    assign w_adv = bus.clk_en && !r_halted;
`else
    assign w_adv = bus.clk_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SEED;
            r_act_seed  <= SEED;
            r_counter   <= '0;
            r_sym_valid <= 1'b0;
            r_seed_err  <= 1'b0;
            r_once      <= 1'b0;
            r_periodic  <= 1'b0;
        end else begin
            r_sym_valid <= 1'b0;
            r_seed_err  <= 1'b0;
            r_periodic  <= 1'b0;
            if (bus.seed_load) begin
                // a zero seed would lock the register, so it is refused outright
                if (w_load_ok) begin
                    r_state    <= bus.seed_in;
                    r_act_seed <= bus.seed_in;
                    r_counter  <= '0;
                    r_once     <= 1'b0;
                end else begin
                    r_seed_err <= 1'b1;
                end
            end else if (w_adv) begin
                r_state     <= w_next;
                r_sym_valid <= 1'b1;
                if (w_wrap) begin
                    r_counter  <= '0;
                    r_periodic <= 1'b1;
                    r_once     <= 1'b1;
                end else begin
                    r_counter  <= r_counter + LEN'(1);
                end
            end
        end
    end

    assign bus.seq_out            = r_state;
    assign bus.sym_out            = r_state[SYM_W-1:0];
    assign bus.sym_valid          = r_sym_valid;
    assign bus.seed_err           = r_seed_err;
    assign bus.cycle_out_once     = r_once;
    assign bus.cycle_out_periodic = r_periodic;
    assign bus.lfsr_counter       = r_counter;

endmodule

// File: tb/tb_lfsr_gen_param.sv
// tb/tb_lfsr_gen_param.sv - table/scoreboard bench for lfsr_gen_param at LEN=4, SYM_W=1 and SYM_W=2
module tb_lfsr_gen_param;

    typedef struct {
        logic       en;
        logic       ld;
        logic [3:0] sin;
        logic [3:0] seq;
        logic [3:0] cnt;
        logic       vld;
        logic       per;
        logic       once;
        logic       err;
        logic       chk2;
        logic [3:0] seq2;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_gen_param_if #(.LEN(4), .SYM_W(1)) bus1 ();
    lfsr_gen_param_if #(.LEN(4), .SYM_W(2)) bus2 ();

    lfsr_gen_param #(.LEN(4), .POLY(4'h3), .SEED(4'h1), .SYM_W(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );
    lfsr_gen_param #(.LEN(4), .POLY(4'h3), .SEED(4'h1), .SYM_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    vec_t sb[$];
    logic [3:0] c1 [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                            4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
    logic [3:0] c2 [15] = '{4'h1, 4'h4, 4'h3, 4'hC, 4'h5, 4'h7, 4'hF, 4'h9,
                            4'h2, 4'h8, 4'h6, 4'hB, 4'hA, 4'hE, 4'hD};
    vec_t tbl [15];
    logic once_x;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic ld, input logic [3:0] sin,
                                input logic [3:0] seq, input logic [3:0] cnt, input logic vld,
                                input logic per, input logic once, input logic err);
        vec_t v;
        v.en = en; v.ld = ld; v.sin = sin; v.seq = seq; v.cnt = cnt;
        v.vld = vld; v.per = per; v.once = once; v.err = err;
        v.chk2 = 1'b0; v.seq2 = 4'h0;
        return v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        bus1.clk_en = v.en; bus1.seed_load = v.ld; bus1.seed_in = v.sin;
        bus2.clk_en = v.en; bus2.seed_load = v.ld; bus2.seed_in = v.sin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " seq"},  int'(bus1.seq_out), int'(e.seq));
        chk({tag, " sym"},  int'(bus1.sym_out), int'(e.seq[0]));
        chk({tag, " vld"},  int'(bus1.sym_valid), int'(e.vld));
        chk({tag, " cnt"},  int'(bus1.lfsr_counter), int'(e.cnt));
        chk({tag, " per"},  int'(bus1.cycle_out_periodic), int'(e.per));
        chk({tag, " once"}, int'(bus1.cycle_out_once), int'(e.once));
        chk({tag, " err"},  int'(bus1.seed_err), int'(e.err));
        if (e.chk2) begin
            chk({tag, " seq2"}, int'(bus2.seq_out), int'(e.seq2));
            chk({tag, " sym2"}, int'(bus2.sym_out), int'(e.seq2[1:0]));
            chk({tag, " cnt2"}, int'(bus2.lfsr_counter), int'(e.cnt));
            chk({tag, " per2"}, int'(bus2.cycle_out_periodic), int'(e.per));
        end
        bus1.clk_en = 1'b0; bus1.seed_load = 1'b0;
        bus2.clk_en = 1'b0; bus2.seed_load = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 15; i++) begin
            tbl[i] = mk(1'b1, 1'b0, 4'h0, c1[(i + 1) % 15], (i == 14) ? 4'h0 : 4'(i + 1),
                        1'b1, i == 14, i == 14, 1'b0);
            tbl[i].chk2 = 1'b1;
            tbl[i].seq2 = c2[(i + 1) % 15];
        end

        reset = 1'b1;
        bus1.clk_en = 1'b0; bus1.seed_load = 1'b0; bus1.seed_in = 4'h0;
        bus2.clk_en = 1'b0; bus2.seed_load = 1'b0; bus2.seed_in = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst seq",  int'(bus1.seq_out), 1);
        chk("rst sym",  int'(bus1.sym_out), 1);
        chk("rst cnt",  int'(bus1.lfsr_counter), 0);
        chk("rst vld",  int'(bus1.sym_valid), 0);
        chk("rst per",  int'(bus1.cycle_out_periodic), 0);
        chk("rst once", int'(bus1.cycle_out_once), 0);
        chk("rst err",  int'(bus1.seed_err), 0);
        chk("rst sym2", int'(bus2.sym_out), 1);

        for (int i = 0; i < 15; i++) apply($sformatf("adv%0d", i + 1), tbl[i]);

`ifdef LFSR_STOP_ON_CYCLE_EN
        for (int i = 0; i < 20; i++) apply("halt", mk(1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        apply("rearm", mk(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        once_x = 1'b0;
`else
        once_x = 1'b1;
`endif
        apply("wrap+1", mk(1'b1, 1'b0, 4'h0, 4'h2, 4'h1, 1'b1, 1'b0, once_x, 1'b0));
        apply("hold1", mk(1'b0, 1'b0, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0, once_x, 1'b0));
        apply("hold2", mk(1'b0, 1'b0, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0, once_x, 1'b0));
        apply("zload", mk(1'b1, 1'b1, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0, once_x, 1'b1));
        apply("zload+1", mk(1'b0, 1'b0, 4'h0, 4'h2, 4'h1, 1'b0, 1'b0, once_x, 1'b0));
        apply("load8", mk(1'b1, 1'b1, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int j = 1; j <= 15; j++) begin
            apply($sformatf("s8 adv%0d", j),
                  mk(1'b1, 1'b0, 4'h0, c1[(3 + j) % 15], (j == 15) ? 4'h0 : 4'(j),
                     1'b1, j == 15, j == 15, 1'b0));
            for (int k = 0; k < 2; k++)
                apply($sformatf("s8 idle%0d", j),
                      mk(1'b0, 1'b0, 4'h0, c1[(3 + j) % 15], (j == 15) ? 4'h0 : 4'(j),
                         1'b0, 1'b0, j == 15, 1'b0));
        end

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst seq",  int'(bus1.seq_out), 1);
        chk("arst cnt",  int'(bus1.lfsr_counter), 0);
        chk("arst once", int'(bus1.cycle_out_once), 0);
        @(negedge clk);
        reset = 1'b0;
        apply("post rst", mk(1'b1, 1'b0, 4'h0, 4'h2, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
